// File: rtl/key_schedule_iterative_pkg.sv
// Shared AES-128 definitions: element types, S-box table and key-schedule helpers.
// Also holds the state encoding of the iterative key expander.
package AESDefinitions;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] roundKey_t;
  typedef logic [127:0] key_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic word_t SubWord(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic word_t RotWord(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_iterative_step.sv
// One AES-128 key-schedule round: next round key from the previous one and rcon.
// Purely combinational; shared by the iterative expander and any unrolled expander.
module key_schedule_step
  import AESDefinitions::*;
(
  input  roundKey_t prev_key,
  input  byte_t     rcon,
  output roundKey_t next_key
);

  word_t w0;
  word_t w1;
  word_t w2;
  word_t w3;

  always_comb begin
    w0 = prev_key[127:96] ^ SubWord(RotWord(prev_key[31:0])) ^ {rcon, 24'h0};
    w1 = prev_key[95:64] ^ w0;
    w2 = prev_key[63:32] ^ w1;
    w3 = prev_key[31:0]  ^ w2;
  end

  assign next_key = {w0, w1, w2, w3};

endmodule

// File: rtl/key_schedule_iterative.sv
// Sequential AES-128 key expander: one round key per clock, all 11 held in registers.
// Optional macro KEY_SCHEDULE_ZEROIZE_EN adds a synchronous zeroize input.
module key_schedule_iterative
  import AESDefinitions::*;
#(
  parameter int unsigned KEY_SIZE  = 128,
  parameter int unsigned KEY_BYTES = KEY_SIZE / 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  key_t                        key,
  output logic                        busy,
  output logic                        done,
  output logic                        keys_valid,
  output roundKey_t [0:NUM_ROUNDS]    roundKeys,
  input  logic [3:0]                  rd_idx,
  output roundKey_t                   rd_key
`ifdef KEY_SCHEDULE_ZEROIZE_EN
 ,input  logic                        zeroize
`endif
);

  if (KEY_SIZE != 128 || KEY_BYTES * 8 != KEY_SIZE) begin : g_bad_key_size
    $error("key_schedule_iterative supports only KEY_SIZE = 128");
  end

  ks_state_t                 state;
  ks_state_t                 state_next;
  logic [3:0]                counter;
  byte_t                     rcon;
  roundKey_t [0:NUM_ROUNDS]  rk;
  roundKey_t                 prev_key;
  roundKey_t                 step_key;
  logic                      zero_req;

`ifdef KEY_SCHEDULE_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  // counter always names the slot being written, so the source is slot counter-1
  always_comb begin
    prev_key = '0;
    for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
      if (counter == 4'(i + 1)) prev_key = rk[i];
    end
  end

  key_schedule_step u_step (
    .prev_key (prev_key),
    .rcon     (rcon),
    .next_key (step_key)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXPAND;
      EXPAND:  if (counter == 4'(NUM_ROUNDS)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (zero_req) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rk         <= '0;
      counter    <= '0;
      rcon       <= 8'h01;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else if (zero_req) begin
      rk         <= '0;
      counter    <= '0;
      rcon       <= 8'h01;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk[0]      <= key;
            counter    <= 4'd1;
            rcon       <= 8'h01;
            keys_valid <= 1'b0;
          end
        end
        EXPAND: begin
          rk[counter] <= step_key;
          rcon        <= xtime(rcon);
          counter     <= counter + 4'd1;
          if (counter == 4'(NUM_ROUNDS)) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) rd_key = rk[rd_idx];
  end

  assign roundKeys = rk;
  assign busy      = (state == EXPAND);

endmodule

// File: tb/tb_key_schedule_iterative.sv
// Self-checking bench for key_schedule_iterative against a FIPS-197 reference model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_key_schedule_iterative;

  logic                 clock;
  logic                 reset_n;
  logic                 start;
  logic [127:0]         key;
  logic                 busy;
  logic                 done;
  logic                 keys_valid;
  logic [0:10][127:0]   roundKeys;
  logic [3:0]           rd_idx;
  logic [127:0]         rd_key;
  logic                 zeroize;

  int checks;
  int failures;

  logic [7:0]   sb     [256];
  logic [127:0] exp_rk [0:10];

  key_schedule_iterative dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .roundKeys  (roundKeys),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
`ifdef KEY_SCHEDULE_ZEROIZE_EN
   ,.zeroize    (zeroize)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    @(negedge clock);
    start = 1'b1;
    key   = k;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (done) break;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'd10);
  endtask

  task automatic check_schedule(input string tag, input logic [127:0] k);
    compute_model(k);
    chk({tag, "_keys_valid"}, 128'(keys_valid), 128'd1);
    for (int r = 0; r < 11; r++) chk($sformatf("%s_rk%0d", tag, r), roundKeys[r], exp_rk[r]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_done"}, 128'(done), 128'd0);
    chk({tag, "_keys_valid"}, 128'(keys_valid), 128'd0);
    for (int r = 0; r < 11; r++) chk($sformatf("%s_rk%0d", tag, r), roundKeys[r], 128'd0);
  endtask

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    int dones;
    int done_cyc;

    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    key      = '0;
    rd_idx   = 4'd0;
    zeroize  = 1'b0;
    build_sbox();

    #12;
    check_cleared("reset");
    chk("reset_rd_key", rd_key, 128'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // FIPS-197 appendix key
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start_key(k1);
    chk("fips_busy", 128'(busy), 128'd1);
    chk("fips_valid_low", 128'(keys_valid), 128'd0);
    wait_done("fips");
    chk("fips_rk1_const", roundKeys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10_const", roundKeys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_schedule("fips", k1);
    tick();
    chk("fips_done_pulse", 128'(done), 128'd0);
    chk("fips_idle", 128'(busy), 128'd0);

    // All-zero key and the read port over the full index range
    start_key(128'd0);
    wait_done("zero");
    chk("zero_rk1_const", roundKeys[1], 128'h62636363626363636263636362636363);
    chk("zero_rk10_const", roundKeys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_schedule("zero", 128'd0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk($sformatf("rd_key_idx%0d", i), rd_key, (i <= 10) ? exp_rk[i] : 128'd0);
    end

    // Random keys
    for (int n = 0; n < 4; n++) begin
      k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_key(k1);
      wait_done($sformatf("rand%0d", n));
      check_schedule($sformatf("rand%0d", n), k1);
    end

    // start and key changes during expansion are ignored
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k1);
    dones = 0;
    done_cyc = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (done) begin
        dones++;
        done_cyc = c;
      end
      if (c == 3 || c == 7) begin
        start = 1'b1;
        key   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("ignore_done_count", 128'(dones), 128'd1);
    chk("ignore_done_cycle", 128'(done_cyc), 128'd10);
    check_schedule("ignore", k1);

    // Back-to-back: restart in the done cycle with the zero key
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k1);
    wait_done("b2b_first");
    check_schedule("b2b_first", k1);
    start = 1'b1;
    key   = 128'd0;
    tick();
    start = 1'b0;
    chk("b2b_valid_drop", 128'(keys_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    chk("b2b_rk0", roundKeys[0], 128'd0);
    wait_done("b2b_second");
    check_schedule("b2b_second", 128'd0);

    // Asynchronous reset in the middle of an expansion
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k1);
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    k2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k2);
    wait_done("after_rst");
    check_schedule("after_rst", k2);

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    // Zeroize beats both a concurrent start and the running expansion
    k1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_key(k1);
    repeat (4) tick();
    zeroize = 1'b1;
    start   = 1'b1;
    key     = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    zeroize = 1'b0;
    start   = 1'b0;
    check_cleared("zeroize");
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("zeroize_no_activity", 128'(dones), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
